// File: rtl/if_id_stage_pkg.sv
// Shared RV32I+Zicsr decode constants for the IF/ID boundary and the immediate generator.
package if_id_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_CSRI  = 3'd5,
    IMM_CSR   = 3'd6,
    IMM_SHAMT = 3'd7
  } imm_sel_e;

  typedef struct packed {
    imm_sel_e imm_sel;
    logic     rf_we;
    logic     mem_we;
    logic     is_load;
    logic     is_branch;
    logic     is_jump;
    logic     csr_we;
    logic     a_sel;
    logic     b_sel;
    logic     illegal;
  } ctrl_t;

endpackage

// File: rtl/if_id_stage_inst_decoder.sv
// Combinational decode of a raw instruction into the ID-side control bundle.
module inst_decoder
  import if_id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign unused_fields = ^{inst[31:15], inst[11:7]};

  always_comb begin
    ctrl.imm_sel   = IMM_I;
    ctrl.rf_we     = 1'b0;
    ctrl.mem_we    = 1'b0;
    ctrl.is_load   = 1'b0;
    ctrl.is_branch = 1'b0;
    ctrl.is_jump   = 1'b0;
    ctrl.csr_we    = 1'b0;
    ctrl.a_sel     = 1'b0;
    ctrl.b_sel     = 1'b1;
    ctrl.illegal   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        ctrl.rf_we = 1'b1;
        if (funct3 == F3_SLL || funct3 == F3_SR) ctrl.imm_sel = IMM_SHAMT;
      end
      OPC_LOAD: begin
        ctrl.rf_we   = 1'b1;
        ctrl.is_load = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ctrl.illegal = 1'b1;
      end
      OPC_JALR: begin
        ctrl.rf_we   = 1'b1;
        ctrl.is_jump = 1'b1;
        if (funct3 != 3'b000) ctrl.illegal = 1'b1;
      end
      OPC_STORE: begin
        ctrl.imm_sel = IMM_S;
        ctrl.mem_we  = 1'b1;
        if (funct3[2] || funct3 == 3'b011) ctrl.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.imm_sel   = IMM_B;
        ctrl.is_branch = 1'b1;
        ctrl.a_sel     = 1'b1;
        ctrl.b_sel     = 1'b0;
        if (funct3 == 3'b010 || funct3 == 3'b011) ctrl.illegal = 1'b1;
      end
      OPC_LUI: begin
        ctrl.imm_sel = IMM_U;
        ctrl.rf_we   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_sel = IMM_U;
        ctrl.rf_we   = 1'b1;
        ctrl.a_sel   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_sel = IMM_J;
        ctrl.rf_we   = 1'b1;
        ctrl.is_jump = 1'b1;
        ctrl.a_sel   = 1'b1;
      end
      OPC_OP: begin
        ctrl.rf_we = 1'b1;
        ctrl.b_sel = 1'b0;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_CSRRW) begin
          ctrl.imm_sel = IMM_CSR;
          ctrl.rf_we   = 1'b1;
          ctrl.csr_we  = 1'b1;
        end else if (funct3 == F3_CSRRWI) begin
          ctrl.imm_sel = IMM_CSRI;
          ctrl.rf_we   = 1'b1;
          ctrl.csr_we  = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary: tracks PC/valid of the arriving BRAM word, holds it across stalls, squashes on flush.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = if_id_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        fetch_valid,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic        mem_we,
  output logic        is_load,
  output logic        is_branch,
  output logic        is_jump,
  output logic        csr_we,
  output logic        a_sel,
  output logic        b_sel,
  output logic        illegal
);

  import if_id_stage_pkg::*;

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] hold_q;
  logic        hold_v;
  logic [31:0] raw;
  ctrl_t       ctrl;

  // BRAM output changes every cycle, so the first stalled cycle snapshots it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      hold_q  <= NOP_INST;
      hold_v  <= 1'b0;
    end else if (flush) begin
      pc_q    <= pc_in;
      valid_q <= 1'b0;
      hold_v  <= 1'b0;
    end else if (stall) begin
      if (!hold_v) begin
        hold_q <= imem_dout;
        hold_v <= 1'b1;
      end
    end else begin
      pc_q    <= pc_in;
      valid_q <= fetch_valid;
      hold_v  <= 1'b0;
    end
  end

  assign raw       = hold_v ? hold_q : imem_dout;
  assign valid_out = valid_q & ~flush;
  assign inst_out  = valid_out ? raw : NOP_INST;
  assign pc_out    = pc_q;

  inst_decoder u_dec (
    .inst (inst_out),
    .ctrl (ctrl)
  );

  // inst_out is already NOP when invalid, so only the side-effect flags need gating.
  assign imm_sel   = ctrl.imm_sel;
  assign a_sel     = ctrl.a_sel;
  assign b_sel     = ctrl.b_sel;
  assign rf_we     = valid_out & ctrl.rf_we & ~ctrl.illegal;
  assign mem_we    = valid_out & ctrl.mem_we & ~ctrl.illegal;
  assign is_load   = valid_out & ctrl.is_load;
  assign is_branch = valid_out & ctrl.is_branch;
  assign is_jump   = valid_out & ctrl.is_jump;
  assign csr_we    = valid_out & ctrl.csr_we;
  assign illegal   = valid_out & ctrl.illegal;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, streaming, stall hold, flush, decode sweep.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_valid;
  logic [31:0] imem_dout;
  logic        stall;
  logic        flush;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic [2:0]  imm_sel;
  logic        rf_we;
  logic        mem_we;
  logic        is_load;
  logic        is_branch;
  logic        is_jump;
  logic        csr_we;
  logic        a_sel;
  logic        b_sel;
  logic        illegal;

  int unsigned n_cmp;
  int unsigned n_err;

  if_id_stage #(
    .RESET_PC (32'h4000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .fetch_valid (fetch_valid),
    .imem_dout   (imem_dout),
    .stall       (stall),
    .flush       (flush),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out),
    .imm_sel     (imm_sel),
    .rf_we       (rf_we),
    .mem_we      (mem_we),
    .is_load     (is_load),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .csr_we      (csr_we),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic [31:0] pc, input logic fv, input logic [31:0] dout,
                       input logic st, input logic fl);
    pc_in       = pc;
    fetch_valid = fv;
    imem_dout   = dout;
    stall       = st;
    flush       = fl;
    settle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_cmp = 0;
    n_err = 0;
    pc_in = '0; fetch_valid = 1'b0; imem_dout = '0; stall = 1'b0; flush = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state, issue first fetch.
    drive(32'h4000_0000, 1'b1, 32'h0, 1'b0, 1'b0);
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_inst", inst_out, 32'h0000_0013);
    check("rst_pc", pc_out, 32'h4000_0000);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    next_cycle();

    // addi x1,x0,5
    drive(32'h4000_0004, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
    check("s0_valid", {31'b0, valid_out}, 32'd1);
    check("s0_pc", pc_out, 32'h4000_0000);
    check("s0_inst", inst_out, 32'h0050_0093);
    check("s0_imm_sel", {29'b0, imm_sel}, 32'd0);
    check("s0_b_sel", {31'b0, b_sel}, 32'd1);
    check("s0_rf_we", {31'b0, rf_we}, 32'd1);
    next_cycle();

    // add x2,x1,x2
    drive(32'h4000_0008, 1'b1, 32'h0020_8133, 1'b0, 1'b0);
    check("s1_pc", pc_out, 32'h4000_0004);
    check("s1_b_sel", {31'b0, b_sel}, 32'd0);
    check("s1_rf_we", {31'b0, rf_we}, 32'd1);
    next_cycle();

    // sw x1,4(x2) enters ID while stall asserts for three cycles.
    drive(32'h4000_000C, 1'b1, 32'h0011_2223, 1'b1, 1'b0);
    check("st0_inst", inst_out, 32'h0011_2223);
    check("st0_imm_sel", {29'b0, imm_sel}, 32'd1);
    check("st0_mem_we", {31'b0, mem_we}, 32'd1);
    next_cycle();
    for (int i = 1; i < 3; i++) begin
      drive(32'h4000_000C, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check("st_hold_inst", inst_out, 32'h0011_2223);
      check("st_hold_pc", pc_out, 32'h4000_0008);
      check("st_hold_mem_we", {31'b0, mem_we}, 32'd1);
      next_cycle();
    end
    // Release cycle still shows the held store; successor issued now.
    drive(32'h4000_000C, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("rel_inst", inst_out, 32'h0011_2223);
    check("rel_pc", pc_out, 32'h4000_0008);
    check("rel_imm_sel", {29'b0, imm_sel}, 32'd1);
    next_cycle();

    // Successor jal x1,8
    drive(32'h4000_0010, 1'b1, 32'h0080_00EF, 1'b0, 1'b0);
    check("succ_inst", inst_out, 32'h0080_00EF);
    check("succ_pc", pc_out, 32'h4000_000C);
    check("succ_is_jump", {31'b0, is_jump}, 32'd1);
    check("succ_imm_sel", {29'b0, imm_sel}, 32'd4);
    check("succ_a_sel", {31'b0, a_sel}, 32'd1);
    next_cycle();

    // Flush with jal in ID.
    drive(32'h4000_0100, 1'b1, 32'h0080_00EF, 1'b0, 1'b1);
    check("fl_valid", {31'b0, valid_out}, 32'd0);
    check("fl_rf_we", {31'b0, rf_we}, 32'd0);
    check("fl_is_jump", {31'b0, is_jump}, 32'd0);
    check("fl_inst", inst_out, 32'h0000_0013);
    next_cycle();
    drive(32'h4000_0104, 1'b1, 32'h0080_00EF, 1'b0, 1'b0);
    check("fl1_valid", {31'b0, valid_out}, 32'd0);
    check("fl1_pc", pc_out, 32'h4000_0100);
    check("fl1_rf_we", {31'b0, rf_we}, 32'd0);
    check("fl1_is_jump", {31'b0, is_jump}, 32'd0);
    next_cycle();

    // Capture jal into the hold register, then flush+stall together.
    drive(32'h4000_0108, 1'b1, 32'h0080_00EF, 1'b1, 1'b0);
    check("fs0_is_jump", {31'b0, is_jump}, 32'd1);
    next_cycle();
    drive(32'h4000_0200, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("fs_valid", {31'b0, valid_out}, 32'd0);
    check("fs_rf_we", {31'b0, rf_we}, 32'd0);
    check("fs_is_jump", {31'b0, is_jump}, 32'd0);
    next_cycle();
    drive(32'h4000_0204, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("fs1_valid", {31'b0, valid_out}, 32'd0);
    check("fs1_pc", pc_out, 32'h4000_0200);
    next_cycle();
    drive(32'h4000_0208, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
    check("fs2_hold_cleared", inst_out, 32'h0050_0093);
    check("fs2_pc", pc_out, 32'h4000_0204);
    next_cycle();

    // Decode sweep.
    drive(32'h4000_020C, 1'b1, 32'h4031_5093, 1'b0, 1'b0);
    check("srai_imm_sel", {29'b0, imm_sel}, 32'd7);
    check("srai_rf_we", {31'b0, rf_we}, 32'd1);
    next_cycle();
    drive(32'h4000_0210, 1'b1, 32'h5110_D073, 1'b0, 1'b0);
    check("csrrwi_imm_sel", {29'b0, imm_sel}, 32'd5);
    check("csrrwi_csr_we", {31'b0, csr_we}, 32'd1);
    next_cycle();
    drive(32'h4000_0214, 1'b1, 32'h5110_9073, 1'b0, 1'b0);
    check("csrrw_imm_sel", {29'b0, imm_sel}, 32'd6);
    check("csrrw_csr_we", {31'b0, csr_we}, 32'd1);
    next_cycle();
    drive(32'h4000_0218, 1'b1, 32'h1234_50B7, 1'b0, 1'b0);
    check("lui_imm_sel", {29'b0, imm_sel}, 32'd3);
    check("lui_a_sel", {31'b0, a_sel}, 32'd0);
    next_cycle();
    drive(32'h4000_021C, 1'b1, 32'h0020_8463, 1'b0, 1'b0);
    check("beq_imm_sel", {29'b0, imm_sel}, 32'd2);
    check("beq_a_sel", {31'b0, a_sel}, 32'd1);
    check("beq_b_sel", {31'b0, b_sel}, 32'd0);
    check("beq_is_branch", {31'b0, is_branch}, 32'd1);
    check("beq_rf_we", {31'b0, rf_we}, 32'd0);
    next_cycle();
    drive(32'h4000_0220, 1'b1, 32'h0000_007F, 1'b0, 1'b0);
    check("bad_opc_illegal", {31'b0, illegal}, 32'd1);
    check("bad_opc_rf_we", {31'b0, rf_we}, 32'd0);
    next_cycle();
    drive(32'h4000_0224, 1'b1, 32'h0000_0073, 1'b0, 1'b0);
    check("ecall_illegal", {31'b0, illegal}, 32'd1);
    check("ecall_csr_we", {31'b0, csr_we}, 32'd0);
    next_cycle();
    drive(32'h4000_0228, 1'b1, 32'h0041_2083, 1'b0, 1'b0);
    check("lw_is_load", {31'b0, is_load}, 32'd1);
    check("lw_illegal", {31'b0, illegal}, 32'd0);
    next_cycle();

    // Reset during a stall discards the held word.
    drive(32'h4000_022C, 1'b1, 32'h0050_0093, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b1;
    drive(32'h4000_0230, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(32'h4000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("rs_valid", {31'b0, valid_out}, 32'd0);
    check("rs_pc", pc_out, 32'h4000_0000);
    check("rs_inst", inst_out, 32'h0000_0013);
    next_cycle();
    drive(32'h4000_0004, 1'b1, 32'h0020_8133, 1'b0, 1'b0);
    check("rs_hold_gone", inst_out, 32'h0020_8133);
    check("rs_valid1", {31'b0, valid_out}, 32'd1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID boundary of the 3-stage core.
- Tracks the PC and valid bit of the instruction whose synchronous-read IMEM/BIOS data arrives this cycle.
- Preserves that instruction across stalls (BRAM output is not holdable), squashes it on flush, and decodes it.
- Drives the immediate generator (inst, imm_sel) and the ID-side control bundle in the same cycle the instruction enters ID.

Parameters:
RESET_PC, 32'h4000_0000, PC reported in ID out of reset (BIOS entry).
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
pc_in  in  32  address issued to IMEM this cycle
fetch_valid  in  1  pc_in is a real fetch
imem_dout  in  32  IMEM/BIOS read data (address presented previous cycle)
stall  in  1  hold the ID instruction (hazard unit)
flush  in  1  squash ID instruction (EX redirect)
inst_out  out  32  ID instruction (feeds immediate generator)
pc_out  out  32  PC of inst_out
valid_out  out  1  inst_out is live
imm_sel  out  3  0=I,1=S,2=B,3=U,4=J,5=CSRRWI,6=CSRRW,7=shift-imm
rf_we  out  1  writes rd
mem_we  out  1  store
is_load, is_branch, is_jump, csr_we  out  1 each
a_sel  out  1  ALU A: 0=rs1, 1=PC
b_sel  out  1  ALU B: 0=rs2, 1=imm
illegal  out  1  valid opcode/funct3 not in RV32I+Zicsr subset

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
- Registers:
  - pc_q: PC of the instruction in ID.
  - valid_q.
  - hold_q, hold_v: captured instruction plus its flag.
- Reset: pc_q=RESET_PC, valid_q=0, hold_v=0, hold_q=NOP_INST.
  - So the first cycle after reset: valid_out=0, inst_out=NOP_INST, all side-effect controls 0.
- Raw instruction: raw = hold_v ? hold_q : imem_dout.
- Zero added latency: a PC issued at cycle t appears in ID at t+1.
- Normal (stall=0, flush=0): pc_q<=pc_in, valid_q<=fetch_valid, hold_v<=0.
- Stall (stall=1, flush=0):
  - pc_q and valid_q hold.
  - If hold_v=0: hold_q<=imem_dout, hold_v<=1. Else hold.
  - The first release cycle (stall=0) still uses hold_q, then clears hold_v.
  - Fetch unit must issue the successor PC in the release cycle.
- Flush:
  - Has priority over stall.
  - valid_out forced 0 combinationally in the flush cycle.
  - Next state: valid_q<=0, hold_v<=0, pc_q<=pc_in. The instruction fetched during the flush cycle is wrong-path.
- Gating:
  - valid_out = valid_q & ~flush.
  - inst_out = valid_out ? raw : NOP_INST.
  - pc_out = pc_q, always.
  - When valid_out=0: rf_we, mem_we, is_load, is_branch, is_jump, csr_we, illegal all 0; imm_sel/a_sel/b_sel decode NOP (I, rs1, imm).
- Decode:
  - OP-IMM funct3 001/101 -> imm_sel 7; other OP-IMM/LOAD/JALR -> 0.
  - STORE -> 1; BRANCH -> 2; LUI/AUIPC -> 3; JAL -> 4.
  - SYSTEM funct3 001 -> 6, 101 -> 5, other funct3 -> illegal.
  - a_sel=1 for AUIPC/JAL/BRANCH; b_sel=0 only for OP and BRANCH.
- Illegal: rf_we=0, mem_we=0, illegal=1 (no trap, flagged only).
- Writes to x0 are not suppressed here.
- Simultaneous stall+flush: treat as flush.
- rst mid-stall: hold discarded, reset values next cycle.

Decomposition:
- Shared header/package: opcode, funct3 and imm_sel constants, plus NOP_INST. The immediate generator uses the same encoding.
- One natural combinational sub-module, inst_decoder: raw instruction -> control bundle.
- if_id_stage owns the sequencing, hold logic and gating.

Test Plan:
- Reset: hold rst 2 cycles, then release with fetch_valid=0 -> valid_out=0, inst_out=0x00000013, pc_out=0x40000000, rf_we=0.
- Stream: issue PC 0x40000000/0x40000004 with dout 0x00500093 then 0x00208133 -> next cycles valid_out=1, pc_out matches, imm_sel=0/b_sel=1, then b_sel=0, rf_we=1.
- Stall across data change: sw 0x00112223 in ID, stall=1 for 3 cycles while dout changes to 0xDEADBEEF -> inst_out stays 0x00112223, imm_sel=1, mem_we=1; the first release cycle is still 0x00112223, then the successor.
- Flush, including flush+stall: flush with jal 0x008000EF in ID -> valid_out=0 that cycle and the next, rf_we=0, is_jump=0; with stall also asserted, the same result and hold_v cleared.
- Decode sweep: srai 0x40315093 -> imm_sel=7; csrrwi 0x5110D073 -> 5, csr_we=1; csrrw 0x51109073 -> 6; lui -> 3; beq -> 2, a_sel=1; opcode 0x7F -> illegal=1, rf_we=0.
